// File: rtl/seven_seg_pkg.sv
// Shared segment encodings, slot geometry and leading-zero helper for the
// multiplexed seven-segment scanner.
package seven_seg_pkg;

    // Active-low cathode patterns, bit 6 = a ... bit 0 = g
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam int unsigned SLOT_SUBTICKS = 16;
    localparam int unsigned MAX_DIGITS    = 8;

    // Bit k set when digit k (k >= 1) and everything above it is a zero
    // nibble with no decimal point; digit 0 is never flagged.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [4*MAX_DIGITS-1:0] digits,
        input logic [MAX_DIGITS-1:0]   dps,
        input int unsigned             n
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  all_zero;
        logic [3:0]            nib;
        logic [2:0]            k3;
        int unsigned           k;
        mask     = '0;
        all_zero = 1'b1;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            k  = MAX_DIGITS - 1 - i;
            k3 = 3'(k);
            if (k < n) begin
                nib      = 4'(digits >> (4 * k));
                all_zero = all_zero & (nib == 4'h0) & ~dps[k3];
                if (k != 0) begin
                    mask[k3] = all_zero;
                end
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational nibble to active-low seven-segment pattern.
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    output logic [6:0] seg
);

    // Decimal digits always decode; 10..15 only in hex mode, else dark
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = hex_mode ? SEG_A : SEG_BLANK;
            4'hB: seg = hex_mode ? SEG_B : SEG_BLANK;
            4'hC: seg = hex_mode ? SEG_C : SEG_BLANK;
            4'hD: seg = hex_mode ? SEG_D : SEG_BLANK;
            4'hE: seg = hex_mode ? SEG_E : SEG_BLANK;
            4'hF: seg = hex_mode ? SEG_F : SEG_BLANK;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_segment_scan_n.sv
// N-digit multiplexed common-anode scanner with double-buffered loading,
// 16-level PWM, sub-tick-0 ghost blanking and leading-zero suppression.
module seven_segment_scan_n
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned TICK_BITS  = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    update_valid,
    output logic                    update_ready,
    input  logic [3:0]              brightness,
    input  logic                    hex_mode,
    input  logic                    blank_lz,
    input  logic                    enable,
    output logic [6:0]              a_to_g,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_start
);

    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    logic [TICK_BITS-1:0]    presc_q, presc_d;
    logic [3:0]              sub_q, sub_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic                    pend_full_q, pend_full_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic                    frame_q, frame_d;

    logic                    tick;
    logic                    boundary;
    logic [3:0]              nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [MAX_DIGITS-1:0]   lz;
    logic [6:0]              dec_seg;

    seven_seg_decoder u_dec (
        .nibble   (nib),
        .hex_mode (hex_mode),
        .seg      (dec_seg)
    );

    // Timebase: prescaler -> sub-tick -> digit index, plus frame boundary
    always_comb begin
        presc_d  = presc_q + 1'b1;
        tick     = (presc_q == '1);
        sub_d    = sub_q;
        idx_d    = idx_q;
        boundary = 1'b0;
        if (tick) begin
            sub_d = sub_q + 1'b1;
            if (sub_q == 4'(SLOT_SUBTICKS - 1)) begin
                boundary = 1'b1;
                idx_d    = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end
        end
        frame_d = boundary && (idx_d == '0);
    end

    // Double buffer: swap on the frame boundary so digit 0 of the new frame
    // already decodes from the freshly promoted data (no torn frame)
    always_comb begin
        act_dig_d   = act_dig_q;
        act_dp_d    = act_dp_q;
        pend_dig_d  = pend_dig_q;
        pend_dp_d   = pend_dp_q;
        pend_full_d = pend_full_q;
        if (frame_d && pend_full_q) begin
            act_dig_d   = pend_dig_q;
            act_dp_d    = pend_dp_q;
            pend_full_d = 1'b0;
        end
        if (update_valid && !pend_full_q) begin
            pend_dig_d  = digits_in;
            pend_dp_d   = dp_in;
            pend_full_d = 1'b1;
        end
    end

    // Output staging: segments reload only at slot boundaries, anodes per sub-tick
    always_comb begin
        lz        = lz_mask(32'(act_dig_d), 8'(act_dp_d), NUM_DIGITS);
        nib       = 4'(act_dig_d >> {idx_d, 2'b00});
        cur_dp    = 1'(act_dp_d >> idx_d);
        cur_blank = blank_lz & 1'(lz >> idx_d);
        seg_d     = seg_q;
        dp_n_d    = dp_n_q;
        anode_d   = anode_q;
        if (boundary) begin
            seg_d  = cur_blank ? SEG_BLANK : dec_seg;
            dp_n_d = ~cur_dp;
        end
        if (tick) begin
            anode_d = '1;
            if (enable && (sub_d != 4'd0) && (sub_d <= brightness)) begin
                anode_d = ~(NUM_DIGITS'(1) << idx_d);
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            sub_q       <= '0;
            idx_q       <= '0;
            act_dig_q   <= '0;
            act_dp_q    <= '0;
            pend_dig_q  <= '0;
            pend_dp_q   <= '0;
            pend_full_q <= 1'b0;
            seg_q       <= SEG_BLANK;
            dp_n_q      <= 1'b1;
            anode_q     <= '1;
            frame_q     <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            sub_q       <= sub_d;
            idx_q       <= idx_d;
            act_dig_q   <= act_dig_d;
            act_dp_q    <= act_dp_d;
            pend_dig_q  <= pend_dig_d;
            pend_dp_q   <= pend_dp_d;
            pend_full_q <= pend_full_d;
            seg_q       <= seg_d;
            dp_n_q      <= dp_n_d;
            anode_q     <= anode_d;
            frame_q     <= frame_d;
        end
    end

    assign update_ready = ~pend_full_q;
    assign a_to_g       = seg_q;
    assign dp_n         = dp_n_q;
    assign anode        = anode_q;
    assign frame_start  = frame_q;

endmodule

// File: tb/tb_seven_segment_scan_n.sv
// Directed self-checking bench for seven_segment_scan_n (4 digits, 4-clk sub-tick).
module tb_seven_segment_scan_n;

    localparam logic [6:0] T0   = 7'b0000001;
    localparam logic [6:0] T1   = 7'b1001111;
    localparam logic [6:0] T2   = 7'b0010010;
    localparam logic [6:0] T3   = 7'b0000110;
    localparam logic [6:0] T4   = 7'b1001100;
    localparam logic [6:0] T5   = 7'b0100100;
    localparam logic [6:0] T6   = 7'b0100000;
    localparam logic [6:0] T7   = 7'b0001111;
    localparam logic [6:0] T8   = 7'b0000000;
    localparam logic [6:0] T9   = 7'b0000100;
    localparam logic [6:0] TA   = 7'b0001000;
    localparam logic [6:0] TB   = 7'b1100000;
    localparam logic [6:0] TC   = 7'b0110001;
    localparam logic [6:0] TBLK = 7'h7F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        update_valid;
    logic        update_ready;
    logic [3:0]  brightness;
    logic        hex_mode;
    logic        blank_lz;
    logic        enable;
    logic [6:0]  a_to_g;
    logic        dp_n;
    logic [3:0]  anode;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    // Expected per-slot contents of the frame under test
    logic [6:0] exp_seg [4];
    logic [3:0] exp_dp;

    seven_segment_scan_n #(.NUM_DIGITS(4), .TICK_BITS(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .digits_in    (digits_in),
        .dp_in        (dp_in),
        .update_valid (update_valid),
        .update_ready (update_ready),
        .brightness   (brightness),
        .hex_mode     (hex_mode),
        .blank_lz     (blank_lz),
        .enable       (enable),
        .a_to_g       (a_to_g),
        .dp_n         (dp_n),
        .anode        (anode),
        .frame_start  (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_exp(input logic [6:0] s3, input logic [6:0] s2,
                           input logic [6:0] s1, input logic [6:0] s0,
                           input logic [3:0] dps);
        exp_seg[3] = s3;
        exp_seg[2] = s2;
        exp_seg[1] = s1;
        exp_seg[0] = s0;
        exp_dp     = dps;
    endtask

    // Walk frame positions n0..n1-1 (n = clocks since frame_start went high),
    // checking anodes, segments and frame_start at each negedge
    task automatic check_range(input string tag, input int n0, input int n1);
        int         slot;
        int         sub;
        logic [3:0] ea;
        logic [7:0] es;
        for (int n = n0; n < n1; n++) begin
            slot = n / 64;
            sub  = (n % 64) / 4;
            ea   = 4'hF;
            if (enable && sub >= 1 && sub <= int'(brightness)) ea[slot] = 1'b0;
            es = {exp_seg[slot], ~exp_dp[slot]};
            checks += 3;
            assert (anode === ea) else begin
                errors++;
                $error("FAIL %s anode n=%0d: observed %b expected %b", tag, n, anode, ea);
            end
            assert ({a_to_g, dp_n} === es) else begin
                errors++;
                $error("FAIL %s seg n=%0d: observed %b expected %b", tag, n, {a_to_g, dp_n}, es);
            end
            assert (frame_start === (n == 0)) else begin
                errors++;
                $error("FAIL %s frame_start n=%0d: observed %b expected %b", tag, n, frame_start, n == 0);
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_frame(input string tag);
        int cnt = 0;
        while (frame_start !== 1'b1 && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        check(tag, 32'(frame_start), 32'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        digits_in    = 16'h0000;
        dp_in        = 4'b0000;
        update_valid = 1'b0;
        brightness   = 4'd15;
        hex_mode     = 1'b1;
        blank_lz     = 1'b0;
        enable       = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst anode", 32'(anode), 32'hF);
        check("rst a_to_g", 32'(a_to_g), 32'h7F);
        check("rst dp_n", 32'(dp_n), 32'd1);
        check("rst ready", 32'(update_ready), 32'd1);
        check("rst frame_start", 32'(frame_start), 32'd0);
        rst_n = 1'b1;

        // 1. Load 1234 with dp on digit 2, full brightness
        digits_in    = 16'h1234;
        dp_in        = 4'b0100;
        update_valid = 1'b1;
        @(negedge clk);
        check("load1 ready low", 32'(update_ready), 32'd0);
        update_valid = 1'b0;
        wait_frame("load1 frame");
        check("load1 ready back", 32'(update_ready), 32'd1);
        set_exp(T1, T2, T3, T4, 4'b0100);
        check_range("f1234 b15", 0, 256);

        // 2. PWM levels and enable
        brightness = 4'd3;
        check_range("f1234 b3", 0, 256);
        brightness = 4'd0;
        check_range("f1234 b0", 0, 256);
        brightness = 4'd15;
        enable     = 1'b0;
        check_range("f1234 en0", 0, 256);
        enable     = 1'b1;

        // 3. Mid-frame update; second valid held until ready returns
        check_range("f1234 pre", 0, 100);
        digits_in    = 16'h5678;
        dp_in        = 4'b0000;
        update_valid = 1'b1;
        @(negedge clk);
        check("upd ready low", 32'(update_ready), 32'd0);
        digits_in = 16'h9ABC;
        check_range("f1234 hold", 101, 256);
        check("upd ready back", 32'(update_ready), 32'd1);
        set_exp(T5, T6, T7, T8, 4'b0000);
        check_range("f5678 start", 0, 1);
        check("upd2 ready low", 32'(update_ready), 32'd0);
        update_valid = 1'b0;
        check_range("f5678", 1, 256);
        set_exp(T9, TA, TB, TC, 4'b0000);
        check_range("f9abc", 0, 256);

        // 5. Capture on the frame_start cycle applies one frame later
        check("fs ready", 32'(update_ready), 32'd1);
        digits_in    = 16'h00A0;
        dp_in        = 4'b0000;
        update_valid = 1'b1;
        check_range("f9abc fs", 0, 1);
        check("fs cap ready low", 32'(update_ready), 32'd0);
        update_valid = 1'b0;
        check_range("f9abc still", 1, 256);

        // 4. Leading-zero blanking and hex/decimal mode
        set_exp(T0, T0, TA, T0, 4'b0000);
        check_range("f00a0 nolz", 0, 200);
        blank_lz = 1'b1;
        check_range("f00a0 nolz tail", 200, 256);
        set_exp(TBLK, TBLK, TA, T0, 4'b0000);
        check_range("f00a0 lz hex", 0, 256);
        hex_mode     = 1'b0;
        dp_in        = 4'b1000;
        update_valid = 1'b1;
        set_exp(TBLK, TBLK, TBLK, T0, 4'b0000);
        check_range("f00a0 lz dec", 0, 1);
        check("dp cap ready low", 32'(update_ready), 32'd0);
        update_valid = 1'b0;
        check_range("f00a0 lz dec", 1, 256);
        set_exp(T0, T0, TBLK, T0, 4'b1000);
        check_range("f00a0 dp3", 0, 256);

        // 6. Reset mid-slot discards pending data
        hex_mode = 1'b1;
        blank_lz = 1'b0;
        set_exp(T0, T0, TA, T0, 4'b1000);
        check_range("f00a0 pre-rst", 0, 100);
        digits_in    = 16'h1234;
        dp_in        = 4'b0000;
        update_valid = 1'b1;
        @(negedge clk);
        check("rst6 ready low", 32'(update_ready), 32'd0);
        update_valid = 1'b0;
        repeat (49) @(negedge clk);
        check("rst6 anode lit", 32'(anode), 32'hB);
        #2 rst_n = 1'b0;
        #1;
        check("arst anode", 32'(anode), 32'hF);
        check("arst a_to_g", 32'(a_to_g), 32'h7F);
        check("arst dp_n", 32'(dp_n), 32'd1);
        check("arst frame_start", 32'(frame_start), 32'd0);
        check("arst ready", 32'(update_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst ready", 32'(update_ready), 32'd1);
        wait_frame("post-rst frame");
        set_exp(T0, T0, T0, T0, 4'b0000);
        check_range("f0000 post-rst", 0, 256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_segment_scan_n.md
Name: seven_segment_scan_n

Overview:
Parametrised multiplexed driver for an N-digit common-anode 7-segment display. It is the next-generation replacement for the fixed 4-digit scanner. It adds:
- double-buffered digit loading with a valid/ready handshake, giving tear-free frame updates;
- 16-level PWM brightness;
- ghost-free anode blanking between digits;
- hex or decimal mode and leading-zero blanking.

It sits between the numeric datapath (BCD/binary counters) and the board's cathode and anode pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal range 2..8.
TICK_BITS, 14, sub-tick period is 2^TICK_BITS clk cycles. Slot = 16 sub-ticks, so 2.62 ms per digit at 100 MHz.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
digits_in  input  4*NUM_DIGITS  nibble k = digit k; digit 0 is rightmost.
dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit.
update_valid  input  1  digits_in/dp_in offered for capture.
update_ready  output  1  pending buffer empty; capture occurs on valid&ready.
brightness  input  4  PWM duty: 0 = dark, 15 = 15/16.
hex_mode  input  1  1 = show 10..15 as A b C d E F; 0 = blank for 10..15.
blank_lz  input  1  1 = blank leading zeros.
enable  input  1  0 = all anodes off; counters keep running.
a_to_g  output  7  cathodes, active-low; a = bit 6 … g = bit 0.
dp_n  output  1  decimal-point cathode, active-low.
anode  output  NUM_DIGITS  digit enables, active-low.
frame_start  output  1  one-clk pulse when the slot of digit 0 begins.

Behaviour:
- Reset (async assert, sync release on clk): anode all 1, a_to_g 7'h7F, dp_n 1, update_ready 1, frame_start 0. Active and pending buffers are 0; pending is flagged empty. Prescaler, sub-tick counter and digit index are all 0.
- Prescaler counts 0..2^TICK_BITS-1. When it wraps it produces a tick.
- The 4-bit sub counter increments on each tick. When it wraps 15->0 it advances the digit index, which wraps NUM_DIGITS-1 -> 0.
- Slot boundary = the tick on which sub becomes 0. On this cycle, and only this cycle, a_to_g and dp_n are reloaded for the new digit index.
- Anode k is driven low when all of the following hold: enable=1, index==k, 1 <= sub <= brightness. Sub=0 is therefore always dark (ghost guard), and brightness=0 keeps the display dark.
- All outputs are registered. Anode, segment and frame_start changes occur one clk after the tick.
- frame_start pulses high for exactly one clk when the index becomes 0.
- Handshake:
  - update_valid & update_ready -> pending <= {digits_in, dp_in}, pending full, update_ready drops the next cycle.
  - At the frame_start cycle, if pending is full: active <= pending, pending emptied, update_ready = 1 the next cycle.
  - A capture on the same cycle as frame_start stays pending until the following frame.
  - update_valid is ignored while ready=0.
- Decode (from active buffer):
  - 0..9 use the standard patterns (0 = 7'b0000001 … 9 = 7'b0000100).
  - 10..15: hex_mode=1 gives A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000. hex_mode=0 gives 7'h7F.
- Leading-zero blank: digit k (k >= 1) is blanked (a_to_g 7'h7F) when blank_lz=1, its nibble and all higher nibbles are 0, and none of its dp or higher dps is set. Digit 0 is never blanked.
- dp_n = ~dp of the current digit, independent of blanking.
- brightness, hex_mode, blank_lz and enable are sampled live; they take effect at the next slot boundary or sub-tick, with no buffering.
- Reset mid-operation: all outputs go to reset values immediately and pending data is discarded.

Decomposition:
- Package seven_seg_pkg holds:
  - segment constants SEG_0..SEG_F and SEG_BLANK (7'h7F);
  - SLOT_SUBTICKS = 16;
  - function lz_mask(digits, dps, N).
- Sub-module seven_seg_decoder: combinational nibble + hex_mode -> a_to_g.
- Scanning, PWM, buffering and handshake stay in the top module.

Test Plan:
All scenarios use TICK_BITS=2 and NUM_DIGITS=4.
1. Reset, then load digits=16'h1234, dp=4'b0100, brightness=15. Per frame, anode cycles 1110, 1101, 1011, 0111. a_to_g on digit 0 = 1001100 (4). dp_n=0 only on digit 2. Each anode is low for 15 of 16 sub-ticks.
2. brightness=3 -> each anode is low exactly 3 ticks (12 clk) per slot and high during sub 0. brightness=0 -> anode stays 4'b1111.
3. Assert update_valid with 16'h5678 mid-frame. ready drops, display keeps showing 1234 until frame_start, then 5678. A second valid held during the wait is captured only after ready returns.
4. digits=16'h00A0, hex_mode=1, blank_lz=1. Digits 3 and 2 are blank (7'h7F), digit 1 = 0001000, digit 0 = 0000001. With hex_mode=0, digit 1 is 7'h7F. With dp_in=4'b1000, no blanking occurs.
5. Capture on the exact frame_start cycle -> data is applied one frame later, not immediately.
6. Deassert rst_n mid-slot. Outputs go to reset values asynchronously, pending is lost, and update_ready=1 after release.
